// File: rtl/assoc_refill_ctrl.sv
// assoc_refill_ctrl: request-side controller for a 4-way fully associative
// cache. It holds the valid/tag/data store and does a registered tag lookup per
// request. On a miss it refills one word from main memory into a victim way.
//
// Optional feature macro: ASSOC_LRU_EN. When it is defined, the victim among
// fully-valid ways is chosen by true LRU using per-way 2-bit ages. When it is
// undefined, the victim is chosen by a round-robin pointer.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    lookup request handshake (ready only in IDLE)
//   req_addr               request address: tag = [11:5], offset [4:0] unused
//   resp_valid             one-cycle response strobe
//   resp_hit, resp_data    hit flag and data word, held between responses
//   mem_req, mem_addr      refill request and block number, held until ack
//   mem_ack, mem_data      refill word return
//   hit_cnt, miss_cnt      saturating hit/miss counters
module assoc_refill_ctrl #(
    parameter int unsigned TAG_W  = 7,
    parameter int unsigned OFF_W  = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [TAG_W+OFF_W-1:0] req_addr,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   mem_req,
    output logic [TAG_W-1:0]       mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_data,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt
);

    localparam int unsigned WAYS  = 4;
    localparam int unsigned WAY_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP
    } state_t;

    state_t                         state_q, state_d;
    logic [TAG_W-1:0]               tag_q, tag_d;
    logic [WAYS-1:0]                valid_q, valid_d;
    logic [WAYS-1:0][TAG_W-1:0]     way_tag_q, way_tag_d;
    logic [WAYS-1:0][DATA_W-1:0]    way_data_q, way_data_d;
    logic                           req_ready_q, req_ready_d;
    logic                           resp_valid_q, resp_valid_d;
    logic                           resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]              resp_data_q, resp_data_d;
    logic                           mem_req_q, mem_req_d;
    logic [TAG_W-1:0]               mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]               hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]               miss_cnt_q, miss_cnt_d;
`ifdef ASSOC_LRU_EN
    logic [WAYS-1:0][1:0]           age_q, age_d;
    logic                           acc_en;
    logic [WAY_W-1:0]               acc_way;
    logic [WAY_W-1:0]               lru_way;
`else
    logic [WAY_W-1:0]               rr_q, rr_d;
`endif

    logic                           hit;
    logic [WAY_W-1:0]               hit_way;
    logic                           inv_found;
    logic [WAY_W-1:0]               inv_way;
    logic [WAY_W-1:0]               victim;

    // Block offset does not select data: one word per block.
    logic unused_off;
    assign unused_off = ^req_addr[OFF_W-1:0];

    // Next-state, storage update and registered-output computation.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        way_tag_d    = way_tag_q;
        way_data_d   = way_data_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_data_d  = resp_data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
`ifdef ASSOC_LRU_EN
        age_d        = age_q;
        acc_en       = 1'b0;
        acc_way      = '0;
        lru_way      = '0;
`else
        rr_d         = rr_q;
`endif
        hit          = 1'b0;
        hit_way      = '0;
        inv_found    = 1'b0;
        inv_way      = '0;

        // Associative compare; at most one way can match.
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && (way_tag_q[i] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
        end

        // Lowest-index invalid way has priority as victim.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end

`ifdef ASSOC_LRU_EN
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == 2'd3) begin
                lru_way = WAY_W'(i);
            end
        end
        victim = inv_found ? inv_way : lru_way;
`else
        victim = inv_found ? inv_way : rr_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d   = req_addr[TAG_W+OFF_W-1:OFF_W];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_data_d  = way_data_q[hit_way];
                    if (hit_cnt_q != '1) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
`ifdef ASSOC_LRU_EN
                    acc_en  = 1'b1;
                    acc_way = hit_way;
`endif
                end else begin
                    state_d    = S_REFILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = tag_q;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    valid_d[victim]    = 1'b1;
                    way_tag_d[victim]  = tag_q;
                    way_data_d[victim] = mem_data;
                    mem_req_d          = 1'b0;
                    state_d            = S_RESP;
                    resp_valid_d       = 1'b1;
                    resp_hit_d         = 1'b0;
                    resp_data_d        = mem_data;
`ifdef ASSOC_LRU_EN
                    acc_en  = 1'b1;
                    acc_way = victim;
`else
                    // Pointer moves only when a valid way is evicted.
                    if (!inv_found) begin
                        rr_d = rr_q + WAY_W'(1);
                    end
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ASSOC_LRU_EN
        // Accessed way becomes youngest; ways younger than it age by one.
        if (acc_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (WAY_W'(i) == acc_way) begin
                    age_d[i] = 2'd0;
                end else if (age_q[i] < age_q[acc_way]) begin
                    age_d[i] = age_q[i] + 2'd1;
                end
            end
        end
`endif

        req_ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            valid_q      <= '0;
            way_tag_q    <= '0;
            way_data_q   <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
`ifdef ASSOC_LRU_EN
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= 2'(i);
            end
`else
            rr_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            way_tag_q    <= way_tag_d;
            way_data_q   <= way_data_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_data_q  <= resp_data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
`ifdef ASSOC_LRU_EN
            age_q        <= age_d;
`else
            rr_q         <= rr_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_data  = resp_data_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_assoc_refill_ctrl.sv
// Scoreboard bench for assoc_refill_ctrl: a cache model built from per-way
// arrays and a recency-ordered queue predicts every response; a monitor
// process compares the DUT responses as they appear.
module tb_assoc_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_data;
    logic        mem_req;
    logic [6:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic        auto_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] auto_data = '0;
    logic [31:0] spur_data = '0;
    assign mem_ack  = auto_ack | spur_ack;
    assign mem_data = spur_ack ? spur_data : auto_data;

    assoc_refill_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_hit  (resp_hit),
        .resp_data (resp_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          hit;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [6:0]  mem_q[$];
    int          tests = 0;
    int          fails = 0;
    int          ack_cycle = -100;
    int          ack_delay = 1;
    bit          mem_auto = 1'b1;
    logic [31:0] salt = '0;

    // Reference cache: per-way arrays plus a most-recent-first way order.
    bit          m_valid[4];
    logic [6:0]  m_tag[4];
    logic [31:0] m_data[4];
    int          m_rr;
    int          m_order[$];
    int          m_hits;
    int          m_miss;

    function automatic logic [31:0] data_of(input logic [6:0] b);
        return 32'(b) ^ salt;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_rr    = 0;
        m_order = {0, 1, 2, 3};
        m_hits  = 0;
        m_miss  = 0;
    endfunction

    function automatic void model_access(input logic [6:0] t, output bit h, output logic [31:0] d);
        int w = -1;
        int idx = -1;
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) w = i;
        h = (w >= 0);
        if (h) begin
            d = m_data[w];
            m_hits++;
        end else begin
            m_miss++;
            for (int i = 3; i >= 0; i--) if (!m_valid[i]) w = i;
            if (w < 0) begin
`ifdef ASSOC_LRU_EN
                w = m_order[$];
`else
                w    = m_rr;
                m_rr = (m_rr + 1) % 4;
`endif
            end
            m_valid[w] = 1'b1;
            m_tag[w]   = t;
            m_data[w]  = data_of(t);
            d          = m_data[w];
        end
        foreach (m_order[k]) if (m_order[k] == w) idx = k;
        if (idx >= 0) m_order.delete(idx);
        m_order.push_front(w);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not as expected (cycle %0d)", name, cyc);
    endtask

    // Issue one request once the DUT is ready; prediction goes to the scoreboard.
    task automatic issue(input logic [11:0] a);
        int          t = 0;
        bit          h;
        logic [31:0] d;
        exp_t        e;
        while (req_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            flag("req_ready_timeout");
            return;
        end
        model_access(a[11:5], h, d);
        e.hit  = h;
        e.data = d;
        e.acc  = cyc;
        sbq.push_back(e);
        if (!h) mem_q.push_back(a[11:5]);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 12'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            flag("resp_timeout");
            sbq.delete();
            mem_q.delete();
        end
        chk("hit_cnt", 64'(hit_cnt), 64'(m_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        mem_q.delete();
        model_reset();
    endtask

    // Monitor: every response strobe must match the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    flag("unexpected_resp");
                end else begin
                    e = sbq.pop_front();
                    chk("resp_hit", 64'(resp_hit), 64'(e.hit));
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                    if (e.hit) chk("hit_latency", 64'(cyc - e.acc), 64'(2));
                    else       chk("miss_latency", 64'(cyc - ack_cycle), 64'(1));
                end
            end
        end
    end

    // Memory responder: checks the fetch address and its stability, acks after ack_delay cycles.
    initial begin
        int         w = 0;
        logic [6:0] held = '0;
        logic [6:0] want;
        forever begin
            @(negedge clk);
            auto_ack = 1'b0;
            if (mem_auto && !rst && mem_req === 1'b1) begin
                if (w == 0) begin
                    held = mem_addr;
                    if (mem_q.size() == 0) begin
                        flag("unexpected_mem_req");
                    end else begin
                        want = mem_q.pop_front();
                        chk("mem_addr", 64'(mem_addr), 64'(want));
                    end
                end else begin
                    chk("mem_addr_stable", 64'(mem_addr), 64'(held));
                    chk("req_ready_low", 64'(req_ready), 64'(0));
                end
                if (w >= ack_delay) begin
                    auto_ack  = 1'b1;
                    auto_data = data_of(mem_addr);
                    ack_cycle = cyc;
                    w         = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_hit", 64'(resp_hit), 64'(0));
        chk("rst_resp_data", 64'(resp_data), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("rst_miss_cnt", 64'(miss_cnt), 64'(0));

        // Cold miss then hit on block 5.
        salt = '0;
        ack_delay = 2;
        issue(12'h0A3); wait_done();
        issue(12'h0A3); wait_done();

        // Fill four ways, then evict with a fifth tag.
        do_reset();
        ack_delay = 0;
        issue(12'hF00); wait_done();
        issue(12'h160); wait_done();
        issue(12'h640); wait_done();
        issue(12'h100); wait_done();
        issue(12'h060); wait_done();
        issue(12'hF00); wait_done();

        // Replacement after a hit refreshes the oldest way.
        do_reset();
        ack_delay = 1;
        issue(12'hF00); wait_done();
        issue(12'h160); wait_done();
        issue(12'h640); wait_done();
        issue(12'h100); wait_done();
        issue(12'hF00); wait_done();
        issue(12'h060); wait_done();
        issue(12'hF00); wait_done();
        issue(12'h160); wait_done();

        // Slow memory.
        ack_delay = 10;
        issue(12'h7E0); wait_done();
        ack_delay = 1;

        // Reset in the fourth REFILL cycle.
        do_reset();
        mem_auto = 1'b0;
        issue(12'h2A0);
        t = 0;
        while (mem_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) flag("mem_req_timeout");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", 64'(mem_req), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(1));
        chk("midrst_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("midrst_miss_cnt", 64'(miss_cnt), 64'(0));
        rst = 1'b0;
        sbq.delete();
        mem_q.delete();
        model_reset();
        mem_auto = 1'b1;
        issue(12'h2A0); wait_done();

        // Counters, then a stray ack while idle.
        do_reset();
        issue(12'h020); wait_done();
        issue(12'h040); wait_done();
        issue(12'h020); wait_done();
        issue(12'h060); wait_done();
        issue(12'h040); wait_done();
        chk("cnt_miss_3", 64'(miss_cnt), 64'(3));
        chk("cnt_hit_2", 64'(hit_cnt), 64'(2));
        @(negedge clk);
        spur_ack  = 1'b1;
        spur_data = 32'hDEAD_BEEF;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        chk("spur_req_ready", 64'(req_ready), 64'(1));
        chk("spur_mem_req", 64'(mem_req), 64'(0));
        chk("spur_hit_cnt", 64'(hit_cnt), 64'(2));
        chk("spur_miss_cnt", 64'(miss_cnt), 64'(3));
        issue(12'h060); wait_done();

        // Random traffic over a small tag set to force hits and evictions.
        salt = 32'h5A5A_0000;
        for (int n = 0; n < 200; n++) begin
            ack_delay = int'($urandom_range(0, 3));
            issue({7'($urandom_range(0, 9)), 5'($urandom)});
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/assoc_refill_ctrl.md
# assoc_refill_ctrl

Request-side controller for the 4-way fully associative cache. It holds the tag, valid and data store, performs a registered tag lookup for each request, and runs a refill FSM against main memory on a miss. The main-memory side is word-per-block: one 32-bit word per 7-bit block number. The block's tag-compare result is the same hit/miss decision as the combinational associative comparator. This block adds storage, replacement and the memory handshake around it.

## Interface
- TAG_W, 7, tag width = addr[11:5]
- OFF_W, 5, block offset width = addr[4:0]; ignored for data selection
- DATA_W, 32, word width
- CNT_W, 16, hit/miss counter width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  lookup request
- req_ready  out  1  high only in IDLE
- req_addr  in  12  request address
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  1 = hit, 0 = serviced by refill
- resp_data  out  DATA_W  word for the requested block
- mem_req  out  1  refill request, held until ack
- mem_addr  out  TAG_W  block number to fetch
- mem_ack  in  1  memory returns mem_data this cycle
- mem_data  in  DATA_W  refill word
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

## Operation
- Storage: 4 ways, each holding valid, tag[6:0] and data[31:0]. Round-robin pointer rr[1:0].
- FSM states: IDLE, LOOKUP, REFILL, RESP.
- IDLE: req_ready=1. When req_valid=1, capture tag=req_addr[11:5] and go to LOOKUP.
- LOOKUP: compare the captured tag against all valid ways.
  - Hit: go to RESP with resp_hit=1 and data from the hit way; hit_cnt+1.
  - Miss: go to REFILL; miss_cnt+1.
- REFILL: mem_req=1 and mem_addr=captured tag, both stable until mem_ack.
  - On mem_ack, write valid, tag and mem_data into the victim way, then go to RESP with resp_hit=0 and resp_data=mem_data.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- Victim selection:
  - The lowest-index invalid way is chosen first.
  - If all ways are valid, way rr is chosen and rr advances by 1 mod 4.
  - rr does not advance when an invalid way is filled.
- mem_ack outside REFILL is ignored.
- Counters saturate at all-ones.
- Duplicate tags cannot occur, because a refill happens only on a miss.

## Timing
- Reset: all valid bits cleared, rr=0, state=IDLE, both counters 0, resp_valid=0, resp_hit=0, resp_data=0, mem_req=0, mem_addr=0. req_ready=1 on the first cycle after reset.
- Hit latency: request accepted in cycle 0, LOOKUP in cycle 1, resp_valid in cycle 2.
- Miss latency: mem_req rises in cycle 2. If mem_ack is sampled in cycle k (k≥2), resp_valid occurs in cycle k+1.
- resp_hit and resp_data are valid only while resp_valid=1 and hold their value otherwise.
- A new request is accepted no earlier than the cycle after RESP.
- Reset during REFILL: the refill is abandoned, no way is written, and mem_req=0 on the next cycle.
- Reset and mem_ack in the same cycle: reset wins.

## Configuration
- ASSOC_LRU_EN defined:
  - Victim selection when all ways are valid uses true LRU instead of rr.
  - Each way has a 2-bit age. An access (hit or fill) sets the accessed way's age to 0 and increments every way whose age was lower.
  - The victim is the way with age 3. Reset sets the ages to 0,1,2,3 for ways 0..3.
  - Invalid-way-first still applies.
- ASSOC_LRU_EN undefined: round-robin rr as described above; no age state exists.

## Test plan
- Cold miss, then hit: after reset, req_addr=12'h0A3 gives mem_req with mem_addr=5. Ack with mem_data=32'd5 gives resp_hit=0, resp_data=5. Repeating 12'h0A3 gives resp_hit=1, resp_data=5, with resp_valid 2 cycles after acceptance.
- Round-robin fill and evict: fill 12'hF00, 12'h160, 12'h640, 12'h100 (tags 120, 11, 50, 8). Then 12'h060 (tag 3) replaces way 0. A following request for 12'hF00 misses, with mem_addr=120.
- LRU (ASSOC_LRU_EN): fill the same four tags, hit 12'hF00, then request tag 3. Tag 11 is evicted. 12'hF00 still hits and 12'h160 misses.
- Slow memory: hold off mem_ack for 10 cycles. mem_req stays 1, mem_addr stays constant, req_ready stays 0, and there is exactly one resp_valid after the ack.
- Reset mid-refill: assert rst in cycle 4 of REFILL. Next cycle: mem_req=0, req_ready=1, counters 0. The same address then misses again.
- Counters and spurious ack: 3 distinct misses plus 2 hits give miss_cnt=3 and hit_cnt=2. A mem_ack pulse in IDLE changes no state.
